// File: rtl/rst_err_ctrl_pkg.sv
// ============================================================================
// Module  : rst_err_ctrl_pkg
// Purpose : Shared definitions for the reset/error controller: the 2-bit FSM
//           state encodings and the default timing parameters.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rst_err_ctrl_pkg;

  // FSM state encodings (2 bits)
  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Default timing parameters
  localparam int RST_CYCLES_DEF  = 4;
  localparam int ERR_PERSIST_DEF = 2;
  localparam int CYC_W_DEF       = 16;

endpackage : rst_err_ctrl_pkg

`default_nettype wire

// File: rtl/rst_err_ctrl_sat_cnt.sv
// ============================================================================
// Module  : sat_cnt
// Purpose : Parameterised-width up-counter with synchronous clear, count
//           enable and saturation at all-ones.
// Ports   : clk    - clock
//           clr_i  - synchronous clear (wins over enable)
//           en_i   - count enable
//           cnt_o  - current count
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : sat_cnt

`default_nettype wire

// File: rtl/rst_err_ctrl.sv
// ============================================================================
// Module  : rst_err_ctrl
// Purpose : Reset and error controller for the processor top level. Holds the
//           processor in reset after rst/restart, counts RUN cycles, filters
//           the processor err output and halts on a persistent error while
//           latching a sticky fault flag and the cycle of recognition.
// Ports   : clk         - clock
//           rst         - synchronous active-high reset
//           err         - processor error indication
//           restart     - single-cycle soft restart request
//           proc_rst    - reset to the processor (high in RST_HOLD and HALT)
//           running     - high in RUN
//           halted      - high in HALT
//           err_latched - sticky fault flag (cleared only by rst)
//           fault_cycle - cycle_cnt value at the final qualifying err sample
//           cycle_cnt   - saturating RUN-cycle counter
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rst_err_ctrl
  import rst_err_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int ERR_PERSIST = ERR_PERSIST_DEF,
  parameter int CYC_W       = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err,
  input  logic             restart,
  output logic             proc_rst,
  output logic             running,
  output logic             halted,
  output logic             err_latched,
  output logic [CYC_W-1:0] fault_cycle,
  output logic [CYC_W-1:0] cycle_cnt
);

  // Widths large enough to hold the terminal values of the small counters.
  localparam int HOLD_W = (RST_CYCLES  < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int PERS_W = (ERR_PERSIST < 2) ? 1 : $clog2(ERR_PERSIST + 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             err_latched_q;
  logic             err_latched_d;
  logic [CYC_W-1:0] fault_cycle_q;
  logic [CYC_W-1:0] fault_cycle_d;

  logic [HOLD_W-1:0] hold_q;
  logic [PERS_W-1:0] pers_q;
  logic [CYC_W-1:0]  cyc_q;

  logic in_hold;
  logic in_run;
  logic in_halt;
  logic hold_done;
  logic restart_ok;
  logic fault;

  assign in_hold    = (state_q == ST_RST_HOLD);
  assign in_run     = (state_q == ST_RUN);
  assign in_halt    = (state_q == ST_HALT);
  assign hold_done  = in_hold && (32'(hold_q) == 32'(RST_CYCLES - 1));
  // restart is only honoured once the processor has left reset hold
  assign restart_ok = restart && (in_run || in_halt);
  // err this cycle completes the run of ERR_PERSIST consecutive samples
  assign fault      = in_run && err && ((32'(pers_q) + 32'd1) == 32'(ERR_PERSIST));

  // Hold counter: counts cycles spent in RST_HOLD, parked at 0 elsewhere.
  sat_cnt #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .clr_i (rst || !in_hold || hold_done),
    .en_i  (in_hold),
    .cnt_o (hold_q)
  );

  // Persistence counter: consecutive err samples while running.
  sat_cnt #(.W(PERS_W)) u_pers_cnt (
    .clk   (clk),
    .clr_i (rst || !in_run || !err || restart_ok),
    .en_i  (in_run && err),
    .cnt_o (pers_q)
  );

  // RUN cycle counter: frozen outside RUN, cleared by rst or restart.
  sat_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk   (clk),
    .clr_i (rst || restart_ok),
    .en_i  (in_run),
    .cnt_o (cyc_q)
  );

  always_comb begin
    state_d       = state_q;
    err_latched_d = err_latched_q;
    fault_cycle_d = fault_cycle_q;

    case (state_q)
      ST_RST_HOLD: if (hold_done) state_d = ST_RUN;
      ST_RUN: begin
        // restart has priority for the state, but a coincident fault is
        // still recorded below
        if (restart)    state_d = ST_RST_HOLD;
        else if (fault) state_d = ST_HALT;
      end
      ST_HALT: if (restart) state_d = ST_RST_HOLD;
      default: state_d = ST_RST_HOLD;
    endcase

    if (fault) begin
      err_latched_d = 1'b1;
      fault_cycle_d = cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RST_HOLD;
      err_latched_q <= 1'b0;
      fault_cycle_q <= '0;
    end else begin
      state_q       <= state_d;
      err_latched_q <= err_latched_d;
      fault_cycle_q <= fault_cycle_d;
    end
  end

  // All outputs decode flop state only.
  assign proc_rst    = !in_run;
  assign running     = in_run;
  assign halted      = in_halt;
  assign err_latched = err_latched_q;
  assign fault_cycle = fault_cycle_q;
  assign cycle_cnt   = cyc_q;

endmodule : rst_err_ctrl

`default_nettype wire
